// File: rtl/spi_arb_pkg.sv
// Shared state encoding, widths and byte-select helper for the SPI transaction arbiter.
package spi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        DONE
    } arb_state_t;

    localparam int BYTES_PER_TXN_DEF = 4;
    localparam int TXN_W             = 32;

    function automatic logic [7:0] byte_sel(input logic [TXN_W-1:0] word, input int unsigned k);
        return word[8*k +: 8];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping, as one-hot grant plus index.
// Purely combinational, zero latency; grant is all-zero when no request is set.
// No backpressure: the caller decides whether to act on the grant.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        int cand;
        logic found;
        cand  = 0;
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int off = 0; off < N; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                gnt   = N'(1) << cand;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares a byte-serial SPI master among NUM_REQ requesters, one 32-bit transaction per grant.
// Registered outputs: ack one cycle after the IDLE sample, first tx_dv at least one cycle later.
// Each byte waits for a master ready rising edge; a per-byte timeout aborts the transaction.
module spi_txn_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ       = 3,
    parameter int BYTES_PER_TXN = BYTES_PER_TXN_DEF,
    parameter int TIMEOUT_CLKS  = 1024
) (
    input  logic                     clk40M,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*TXN_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ack,
    output logic [NUM_REQ-1:0]       txn_done,
    output logic                     txn_err,
    output logic [TXN_W-1:0]         rx_data,
    output logic                     busy,
    output logic [7:0]               spi_tx_byte,
    output logic                     spi_tx_dv,
    input  logic                     spi_tx_ready,
    input  logic                     spi_rx_dv,
    input  logic [7:0]               spi_rx_byte
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = (BYTES_PER_TXN > 1) ? $clog2(BYTES_PER_TXN) : 1;
    localparam int CW = $clog2(BYTES_PER_TXN + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [BW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [TXN_W-1:0]     hold_q, hold_d;
    logic [TXN_W-1:0]     acc_q, acc_d;
    logic [TXN_W-1:0]     rx_data_q, rx_data_d;
    logic [NUM_REQ-1:0]   owner_q, owner_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic [NUM_REQ-1:0]   txn_done_q, txn_done_d;
    logic                 txn_err_q, txn_err_d;
    logic                 busy_q, busy_d;
    logic                 tx_dv_q, tx_dv_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 ready_dly_q;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic                 ready_edge;
    logic                 finish;
    logic                 finish_err;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        rx_cnt_d   = rx_cnt_q;
        tmo_d      = tmo_q;
        hold_d     = hold_q;
        acc_d      = acc_q;
        rx_data_d  = rx_data_q;
        owner_d    = owner_q;
        req_ack_d  = '0;
        txn_done_d = '0;
        txn_err_d  = 1'b0;
        busy_d     = busy_q;
        tx_dv_d    = 1'b0;
        tx_byte_d  = tx_byte_q;
        finish     = 1'b0;
        finish_err = 1'b0;
        ready_edge = spi_tx_ready && !ready_dly_q;

        // Capture runs ahead of the state decode so a final-edge MISO byte lands in acc_d.
        if ((state_q == SEND || state_q == WAIT) && spi_rx_dv && (rx_cnt_q < CW'(BYTES_PER_TXN))) begin
            acc_d[8*rx_cnt_q +: 8] = spi_rx_byte;
            rx_cnt_d               = rx_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ack_d = pick_gnt;
                    owner_d   = pick_gnt;
                    hold_d    = req_data[pick_idx*TXN_W +: TXN_W];
                    acc_d     = '0;
                    rx_cnt_d  = '0;
                    idx_d     = '0;
                    tmo_d     = TW'(TIMEOUT_CLKS);
                    ptr_d     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                tmo_d = tmo_q - 1'b1;
                if (spi_tx_ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = byte_sel(hold_q, 32'(idx_q));
                    tmo_d     = TW'(TIMEOUT_CLKS);
                    state_d   = WAIT;
                end else if (tmo_q <= TW'(1)) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            WAIT: begin
                tmo_d = tmo_q - 1'b1;
                if (ready_edge) begin
                    if (idx_q == BW'(BYTES_PER_TXN - 1)) begin
                        finish = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEND;
                    end
                end else if (tmo_q <= TW'(1)) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Done is flagged on entry so the pulse is visible during the DONE cycle itself.
        if (finish) begin
            txn_done_d = owner_q;
            txn_err_d  = finish_err;
            rx_data_d  = acc_d;
            state_d    = DONE;
        end
    end

    always_ff @(posedge clk40M) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            rx_cnt_q    <= '0;
            tmo_q       <= '0;
            hold_q      <= '0;
            acc_q       <= '0;
            rx_data_q   <= '0;
            owner_q     <= '0;
            req_ack_q   <= '0;
            txn_done_q  <= '0;
            txn_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            tx_dv_q     <= 1'b0;
            tx_byte_q   <= '0;
            ready_dly_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            rx_cnt_q    <= rx_cnt_d;
            tmo_q       <= tmo_d;
            hold_q      <= hold_d;
            acc_q       <= acc_d;
            rx_data_q   <= rx_data_d;
            owner_q     <= owner_d;
            req_ack_q   <= req_ack_d;
            txn_done_q  <= txn_done_d;
            txn_err_q   <= txn_err_d;
            busy_q      <= busy_d;
            tx_dv_q     <= tx_dv_d;
            tx_byte_q   <= tx_byte_d;
            ready_dly_q <= spi_tx_ready;
        end
    end

    assign req_ack     = req_ack_q;
    assign txn_done    = txn_done_q;
    assign txn_err     = txn_err_q;
    assign rx_data     = rx_data_q;
    assign busy        = busy_q;
    assign spi_tx_dv   = tx_dv_q;
    assign spi_tx_byte = tx_byte_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a behavioural byte-serial SPI master.
`timescale 1ns/1ps
module tb_spi_txn_arbiter;

    localparam int NUM_REQ   = 3;
    localparam int TMO       = 16;
    localparam int BYTE_CLKS = 5;
    localparam int BOUND     = 3000;

    typedef struct packed {
        logic [NUM_REQ-1:0] who;
        logic               err;
        logic [31:0]        rx;
    } done_t;

    logic                   clk40M = 1'b0;
    logic                   rst = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*32-1:0]  req_data = '0;
    logic [NUM_REQ-1:0]     req_ack;
    logic [NUM_REQ-1:0]     txn_done;
    logic                   txn_err;
    logic [31:0]            rx_data;
    logic                   busy;
    logic [7:0]             spi_tx_byte;
    logic                   spi_tx_dv;
    logic                   spi_tx_ready = 1'b1;
    logic                   spi_rx_dv = 1'b0;
    logic [7:0]             spi_rx_byte = '0;

    logic [NUM_REQ-1:0] ack_q[$];
    logic [7:0]         tx_q[$];
    logic [7:0]         miso_q[$];
    done_t              done_q[$];

    int checks = 0, errors = 0, cyc = 0;
    int ack_count = 0, exp_acks = 0, dv_count = 0;
    int last_ack_cyc = 0, last_dv_cyc = 0, last_done_cyc = 0;
    int stall_after = 0;
    bit auto_drop = 1'b1;

    spi_txn_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .BYTES_PER_TXN (4),
        .TIMEOUT_CLKS  (TMO)
    ) dut (
        .clk40M       (clk40M),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .txn_done     (txn_done),
        .txn_err      (txn_err),
        .rx_data      (rx_data),
        .busy         (busy),
        .spi_tx_byte  (spi_tx_byte),
        .spi_tx_dv    (spi_tx_dv),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_dv    (spi_rx_dv),
        .spi_rx_byte  (spi_rx_byte)
    );

    always #5 clk40M = ~clk40M;

    initial forever begin
        @(posedge clk40M);
        cyc++;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [63:0] outvec();
        return 64'({req_ack, txn_done, txn_err, busy, spi_tx_dv, spi_tx_byte, rx_data});
    endfunction

    task automatic expect_txn(input logic [NUM_REQ-1:0] who, input logic [31:0] payload,
                              input int nbytes, input logic [31:0] miso,
                              input bit err, input bit with_done, input logic [31:0] exp_rx);
        done_t d;
        ack_q.push_back(who);
        exp_acks++;
        for (int k = 0; k < nbytes; k++) begin
            tx_q.push_back(payload[8*k +: 8]);
            miso_q.push_back(miso[8*k +: 8]);
        end
        if (with_done) begin
            d.who = who;
            d.err = err;
            d.rx  = exp_rx;
            done_q.push_back(d);
        end
    endtask

    task automatic wait_acks(input int target, input string tag);
        int n = 0;
        while (ack_count < target && n < BOUND) begin
            @(negedge clk40M);
            n++;
        end
        chk({"ack_wait_", tag}, 64'(ack_count >= target), 64'(1));
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((ack_q.size() != 0 || tx_q.size() != 0 || done_q.size() != 0 || busy) && n < BOUND) begin
            @(negedge clk40M);
            n++;
        end
        chk({"quiet_", tag}, 64'(n < BOUND), 64'(1));
    endtask

    // Behavioural SPI master: ready drops on tx_dv, returns with rx_dv after BYTE_CLKS.
    initial begin
        int  m_cnt = 0;
        int  m_nbytes = 0;
        bit  m_busy = 1'b0;
        forever begin
            @(negedge clk40M);
            spi_rx_dv = 1'b0;
            if (rst) begin
                m_busy       = 1'b0;
                m_nbytes     = 0;
                spi_tx_ready = 1'b1;
            end else begin
                if (req_ack != '0) m_nbytes = 0;
                if (m_busy) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_busy      = 1'b0;
                        spi_rx_dv   = 1'b1;
                        spi_rx_byte = 8'h00;
                        if (miso_q.size() != 0) spi_rx_byte = miso_q.pop_front();
                        spi_tx_ready = !(stall_after != 0 && m_nbytes == stall_after);
                    end
                end else if (spi_tx_dv) begin
                    m_nbytes++;
                    spi_tx_ready = 1'b0;
                    m_busy       = 1'b1;
                    m_cnt        = BYTE_CLKS;
                end else if (stall_after == 0) begin
                    spi_tx_ready = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk40M);
        if (auto_drop) req_valid = req_valid & ~req_ack;
    end

    // Monitor: pops scoreboard entries whenever the DUT presents ack, tx_dv or done.
    initial begin
        logic               prev_dv = 1'b0;
        logic [NUM_REQ-1:0] exp_ack;
        logic [8:0]         exp_tx;
        done_t              exp_done;
        forever begin
            @(negedge clk40M);
            if (req_ack != '0) begin
                exp_ack = '0;
                if (ack_q.size() != 0) exp_ack = ack_q.pop_front();
                chk("ack", 64'(req_ack), 64'(exp_ack));
                chk("busy_with_ack", 64'(busy), 64'(1));
                ack_count++;
                last_ack_cyc = cyc;
            end
            if (spi_tx_dv) begin
                exp_tx = '0;
                if (tx_q.size() != 0) exp_tx = {1'b1, tx_q.pop_front()};
                chk("tx_byte", 64'({1'b1, spi_tx_byte}), 64'(exp_tx));
                chk("tx_dv_one_cycle", 64'(prev_dv), 64'(0));
                dv_count++;
                last_dv_cyc = cyc;
            end
            if (txn_done != '0) begin
                exp_done = '0;
                if (done_q.size() != 0) exp_done = done_q.pop_front();
                chk("done_err_rx", 64'({txn_done, txn_err, rx_data}), 64'(exp_done));
                chk("busy_at_done", 64'(busy), 64'(1));
                last_done_cyc = cyc;
            end
            prev_dv = spi_tx_dv;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base_dv, d_cyc, n;
        logic [31:0] m;

        repeat (3) @(negedge clk40M);
        chk("reset_outputs", outvec(), 64'(0));
        rst = 1'b0;
        @(negedge clk40M);

        // All three held high: strict rotation 0,1,2,0,1,2.
        auto_drop = 1'b0;
        req_data  = {32'hCCBB_AA99, 32'h8877_6655, 32'h4433_2211};
        for (int t = 0; t < 6; t++) begin
            m = {8'(16*t + 4), 8'(16*t + 3), 8'(16*t + 2), 8'(16*t + 1)};
            expect_txn(NUM_REQ'(1) << (t % 3), req_data[(t % 3)*32 +: 32], 4, m, 1'b0, 1'b1, m);
        end
        base      = ack_count;
        req_valid = '1;
        wait_acks(base + 6, "rr");
        req_valid = '0;
        auto_drop = 1'b1;
        wait_quiet("rr");

        // Single requester 1.
        req_data[63:32] = 32'h0001_0030;
        expect_txn(3'b010, 32'h0001_0030, 4, 32'hDDCC_BBAA, 1'b0, 1'b1, 32'hDDCC_BBAA);
        req_valid[1] = 1'b1;
        wait_quiet("single");

        // Request raised during another transaction's DONE cycle.
        req_data[31:0]  = 32'h0000_0001;
        req_data[95:64] = 32'h0000_0002;
        expect_txn(3'b001, 32'h0000_0001, 4, 32'h4433_2211, 1'b0, 1'b1, 32'h4433_2211);
        expect_txn(3'b100, 32'h0000_0002, 4, 32'h8877_6655, 1'b0, 1'b1, 32'h8877_6655);
        req_valid[0] = 1'b1;
        n = 0;
        while (txn_done == '0 && n < BOUND) begin
            @(negedge clk40M);
            n++;
        end
        req_valid[2] = 1'b1;
        d_cyc = cyc;
        base  = ack_count;
        wait_acks(base + 1, "done_cycle");
        chk("grant_after_done", 64'(last_ack_cyc - d_cyc), 64'(2));
        wait_quiet("done_cycle");

        // Requester 1 blips valid while requester 0 is being served.
        req_data[31:0] = 32'hA5A5_5A5A;
        expect_txn(3'b001, 32'hA5A5_5A5A, 4, 32'h0403_0201, 1'b0, 1'b1, 32'h0403_0201);
        base = ack_count;
        req_valid[0] = 1'b1;
        wait_acks(base + 1, "drop");
        repeat (3) @(negedge clk40M);
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk40M);
        req_valid[1] = 1'b0;
        wait_quiet("drop");
        repeat (10) @(negedge clk40M);
        chk("drop_no_ack", 64'(ack_count), 64'(exp_acks));

        // Master ready stuck low after byte 2.
        stall_after    = 2;
        req_data[31:0] = 32'hDEAD_BEEF;
        expect_txn(3'b001, 32'hDEAD_BEEF, 2, 32'h0000_6B5A, 1'b1, 1'b1, 32'h0000_6B5A);
        req_valid[0] = 1'b1;
        wait_quiet("timeout");
        chk("timeout_latency", 64'(last_done_cyc - last_dv_cyc), 64'(TMO));
        stall_after = 0;
        repeat (5) @(negedge clk40M);
        chk("rx_hold", 64'(rx_data), 64'(32'h0000_6B5A));

        // Reset during byte 3 with requesters 1 and 2 pending.
        req_data[63:32] = 32'h1234_5678;
        req_data[95:64] = 32'hCCBB_AA99;
        expect_txn(3'b010, 32'h1234_5678, 3, 32'h0003_0201, 1'b0, 1'b0, 32'h0);
        base    = ack_count;
        base_dv = dv_count;
        req_valid[1] = 1'b1;
        wait_acks(base + 1, "rst");
        @(negedge clk40M);
        req_valid = req_valid | 3'b110;
        n = 0;
        while (dv_count < base_dv + 3 && n < BOUND) begin
            @(negedge clk40M);
            n++;
        end
        chk("third_byte_seen", 64'(dv_count >= base_dv + 3), 64'(1));
        repeat (2) @(negedge clk40M);
        rst = 1'b1;
        @(negedge clk40M);
        chk("rst_mid_outputs", outvec(), 64'(0));
        miso_q.delete();
        expect_txn(3'b010, 32'h1234_5678, 4, 32'hC4C3_C2C1, 1'b0, 1'b1, 32'hC4C3_C2C1);
        expect_txn(3'b100, 32'hCCBB_AA99, 4, 32'hD4D3_D2D1, 1'b0, 1'b1, 32'hD4D3_D2D1);
        rst = 1'b0;
        wait_quiet("after_rst");

        repeat (5) @(negedge clk40M);
        chk("ack_total", 64'(ack_count), 64'(exp_acks));
        chk("queues_empty", 64'(ack_q.size() + tx_q.size() + done_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
